fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Control and output-register stage of the 8-entry x 32-bit FIFO.
- Owns the head (read) pointer, tail (write) pointer, occupancy count and operation state machine.
- Drives one-hot write selects into the eight data registers and the read address into the downstream 8:1 read mux.
- Captures the mux output into a registered data output, with ack/error handshake flags.

Parameters:
- WIDTH, 32, data word width
- ADDR_W, 3, pointer width; depth = 2**ADDR_W = 8 (fixed by the 8:1 read mux)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request, sampled at clk rise
- rd_en  input  1  read request, sampled at clk rise
- rd_data  input  WIDTH  output of read mux, selected by rd_addr
- wr_sel  output  8  one-hot register write enable (combinational)
- rd_addr  output  ADDR_W  current head pointer, feeds read mux
- d_out  output  WIDTH  registered read data
- full  output  1  count == 8
- empty  output  1  count == 0
- wr_ack  output  1  previous cycle's write accepted
- wr_err  output  1  previous cycle's write rejected (full)
- rd_ack  output  1  previous cycle's read accepted; d_out valid
- rd_err  output  1  previous cycle's read rejected (empty)
- data_count  output  ADDR_W+1  occupancy 0..8

Behaviour:
- Reset (async, immediate): state=INIT, head=0, tail=0, count=0, d_out=0, empty=1, full=0, all acks/errs=0, wr_sel=0.
- Operation decode, per cycle on sampled inputs:
  - Write op: wr_en & ~rd_en.
  - Read op: rd_en & ~wr_en.
  - wr_en & rd_en: NO_OP; no pointer change, no ack, no error.
  - Neither asserted: NO_OP.
- Accepted write (write op & ~full):
  - wr_sel = one-hot(tail) combinationally in the same cycle; the register file captures at that edge.
  - At the edge: tail <= tail+1 mod 8, count+1, state <= WRITE.
- Rejected write (write op & full): wr_sel=0, no change, state <= WR_ERROR.
- Accepted read (read op & ~empty):
  - At the edge: d_out <= rd_data (entry at head), head <= head+1 mod 8, count-1, state <= READ.
- Rejected read (read op & empty): d_out holds, state <= RD_ERROR.
- Otherwise state <= NO_OP.
- States: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. Every state transitions purely on the decode above; INIT exits on the first clk edge after reset release, and requests are honoured at that edge.
- Moore outputs:
  - wr_ack=1 in WRITE only; wr_err=1 in WR_ERROR only.
  - rd_ack=1 in READ only; rd_err=1 in RD_ERROR only.
  - Each flag is high exactly one cycle per operation.
- Latency: write visible to the read mux the cycle after acceptance; read data on d_out one cycle after the request, coincident with rd_ack.
- full/empty/data_count: derived from the count register, so they update the same edge as the pointers.
- Wrap-around: pointers wrap 7->0 silently; full and empty are distinguished by count, never by pointer equality.
- d_out holds its last value in all states other than the cycle following an accepted read.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined: adds outputs almost_full (count==7) and almost_empty (count==1), updating with count.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - state encoding constants (INIT=3'b000, NO_OP=3'b001, WRITE=3'b010, WR_ERROR=3'b011, READ=3'b100, RD_ERROR=3'b101)
  - DEPTH=8
  - default WIDTH
- Sub-module fifo_next_state: combinational next-state, next head/tail/count, and wr_sel decode from (state, wr_en, rd_en, head, tail, count).
- Top level: state/pointer/count/d_out registers plus Moore output decode.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, data_count=0, d_out=0, all acks/errs 0.
- Write 0x11..0x88 on 8 consecutive cycles -> wr_sel 0x01,0x02,...,0x80; wr_ack each following cycle; full=1 and data_count=8 after the 8th edge.
- 9th write while full -> wr_sel=0, wr_err=1 for one cycle, tail and count unchanged.
- Read 8 times -> d_out 0x11..0x88 in order, each with rd_ack; then empty=1; a 9th read gives rd_err=1 and d_out stays 0x88.
- Wrap: write 5, read 5, write 6 -> tail wraps 7->0 (wr_sel 0x80 then 0x01), reads return the 6 values in order, data_count tracks 6->0.
- wr_en & rd_en together with count=3 -> no acks/errs, count stays 3; assert reset mid-burst -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and sizing for the 8-entry FIFO controller.
// Optional almost_full/almost_empty flags are enabled by FIFO_ALMOST_FLAGS_EN.
package fifo_pkg;

  localparam int DEPTH     = 8;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

endpackage

// File: rtl/fifo_next_state.sv
// fifo_next_state: operation decode, next pointers/count/state and the
// one-hot write select for the data registers.
module fifo_next_state
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] head,
  input  logic [ADDR_W-1:0] tail,
  input  logic [ADDR_W:0]   count,
  output state_t            state_nxt,
  output logic [ADDR_W-1:0] head_nxt,
  output logic [ADDR_W-1:0] tail_nxt,
  output logic [ADDR_W:0]   count_nxt,
  output logic              rd_take,
  output logic [DEPTH-1:0]  sel
);

  localparam int CW = ADDR_W + 1;

  logic wr_op;
  logic rd_op;
  logic is_full;
  logic is_empty;

  assign wr_op    = wr_en & ~rd_en;
  assign rd_op    = rd_en & ~wr_en;
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  always_comb begin
    state_nxt = NO_OP;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    rd_take   = 1'b0;
    sel       = '0;
    unique case (1'b1)
      wr_op && !is_full: begin
        sel       = DEPTH'(1) << tail;
        tail_nxt  = tail + ADDR_W'(1);
        count_nxt = count + CW'(1);
        state_nxt = WRITE;
      end
      wr_op && is_full: begin
        state_nxt = WR_ERROR;
      end
      rd_op && !is_empty: begin
        rd_take   = 1'b1;
        head_nxt  = head + ADDR_W'(1);
        count_nxt = count - CW'(1);
        state_nxt = READ;
      end
      rd_op && is_empty: begin
        state_nxt = RD_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/state registers, registered read data and flags.
// Define FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [DEPTH-1:0]  wr_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  d_out,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic [ADDR_W:0]   data_count
);

  localparam int CW = ADDR_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] head_nxt;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W-1:0] tail_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              rd_take;
  logic [DEPTH-1:0]  sel;

  fifo_next_state #(
    .ADDR_W(ADDR_W)
  ) u_next (
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .state_nxt(state_nxt),
    .head_nxt (head_nxt),
    .tail_nxt (tail_nxt),
    .count_nxt(count_nxt),
    .rd_take  (rd_take),
    .sel      (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      d_out <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      if (rd_take) d_out <= rd_data;
    end
  end

  // Held in reset, no register may be written even with wr_en high.
  assign wr_sel     = reset ? '0 : sel;
  assign rd_addr    = head;
  assign data_count = count;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign wr_ack     = (state == WRITE);
  assign wr_err     = (state == WR_ERROR);
  assign rd_ack     = (state == READ);
  assign rd_err     = (state == RD_ERROR);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count == CW'(DEPTH - 1));
  assign almost_empty = (count == CW'(1));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed plan plus random traffic against a queue model,
// with a bench-side register file and read mux around the controller.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [7:0]  wr_sel;
  logic [2:0]  rd_addr;
  logic [31:0] d_out;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [3:0]  data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  logic [31:0] wdata;
  logic [31:0] regs [8];

  int checks = 0;
  int fails  = 0;

  // model state
  int unsigned q[$];
  logic [2:0]  hm;
  logic [2:0]  tm;
  logic [31:0] ed;
  logic        ewa, ewe, era, ere;

  fifo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .wr_sel    (wr_sel),
    .rd_addr   (rd_addr),
    .d_out     (d_out),
    .full      (full),
    .empty     (empty),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err),
    .rd_ack    (rd_ack),
    .rd_err    (rd_err),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`endif
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (wr_sel[i]) regs[i] <= wdata;
  end

  assign rd_data = regs[rd_addr];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hm  = '0;
    tm  = '0;
    ed  = '0;
    ewa = 0; ewe = 0; era = 0; ere = 0;
  endtask

  task automatic check_all();
    chk("data_count", 32'(data_count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("d_out", d_out, ed);
    chk("rd_addr", 32'(rd_addr), 32'(hm));
    chk("wr_ack", 32'(wr_ack), 32'(ewa));
    chk("wr_err", 32'(wr_err), 32'(ewe));
    chk("rd_ack", 32'(rd_ack), 32'(era));
    chk("rd_err", 32'(rd_err), 32'(ere));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("almost_full", 32'(almost_full), 32'(q.size() == 7));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() == 1));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d);
    logic       wop, rop;
    logic [7:0] one;
    logic [7:0] esel;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wdata = d;
    #1;
    wop  = w && !r;
    rop  = r && !w;
    one  = 8'h01;
    esel = (wop && q.size() < 8) ? (one << tm) : 8'h00;
    chk("wr_sel", 32'(wr_sel), 32'(esel));
    @(posedge clk);
    ewa = 0; ewe = 0; era = 0; ere = 0;
    if (wop) begin
      if (q.size() < 8) begin
        q.push_back(d);
        tm  = tm + 3'd1;
        ewa = 1;
      end else ewe = 1;
    end
    if (rop) begin
      if (q.size() > 0) begin
        ed  = q.pop_front();
        hm  = hm + 3'd1;
        era = 1;
      end else ere = 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    model_reset();
    #2;
    check_all();
    chk("wr_sel_rst", 32'(wr_sel), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // idle
    repeat (3) step(0, 0, 0);
    chk("idle_d_out", d_out, 32'h0);
    chk("idle_empty", 32'(empty), 32'h1);

    // fill
    for (int i = 1; i <= 8; i++) step(1, 0, 32'(i * 32'h11));
    chk("fill_count", 32'(data_count), 32'd8);
    chk("fill_full", 32'(full), 32'h1);

    // overflow
    step(1, 0, 32'hdead);
    chk("ovf_wr_err", 32'(wr_err), 32'h1);
    chk("ovf_count", 32'(data_count), 32'd8);
    step(0, 0, 0);
    chk("ovf_err_once", 32'(wr_err), 32'h0);

    // drain
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0);
      chk("drain_d_out", d_out, 32'(i * 32'h11));
    end
    chk("drain_empty", 32'(empty), 32'h1);
    step(0, 1, 0);
    chk("udf_rd_err", 32'(rd_err), 32'h1);
    chk("udf_d_out", d_out, 32'h88);

    // wrap
    for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h200 + 32'(i));
    chk("wrap_count", 32'(data_count), 32'd6);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      chk("wrap_d_out", d_out, 32'h200 + 32'(i));
    end

    // simultaneous request
    for (int i = 0; i < 3; i++) step(1, 0, 32'h300 + 32'(i));
    step(1, 1, 32'hbeef);
    chk("both_count", 32'(data_count), 32'd3);

    // async reset mid-burst
    step(1, 0, 32'h400);
    @(negedge clk);
    wr_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_wr_sel", 32'(wr_sel), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic w, r;
      w = ($urandom_range(99) < 55);
      r = ($urandom_range(99) < 45);
      step(w, r, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
